// File: rtl/output_layer_accum.sv
// Final fully-connected layer: accumulates ten bias-initialised, saturating neuron sums
// over N_IN streamed activations, then emits them with a single-cycle valid pulse.
module output_layer_accum #(
    parameter int DATA_WIDTH = 29,
    parameter int ACT_WIDTH  = 8,
    parameter int W_WIDTH    = 8,
    parameter int N_IN       = 784
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ACT_WIDTH-1:0]    act,
    input  logic [10*W_WIDTH-1:0]   weights,
    input  logic [10*DATA_WIDTH-1:0] bias,
    output logic [10*DATA_WIDTH-1:0] layer_out,
    output logic                    valid,
    output logic                    overflow
);

    localparam int N_NEURON = 10;
    localparam int PROD_W   = ACT_WIDTH + W_WIDTH;
    localparam int SUM_W    = DATA_WIDTH + 1;
    localparam int CNT_W    = $clog2(N_IN + 1);
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(N_IN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EMIT = 2'd2
    } state_t;

    // A wide sum whose two top bits disagree has left the DATA_WIDTH range.
    function automatic logic sat_hit(input logic [SUM_W-1:0] sum);
        return sum[SUM_W-1] ^ sum[SUM_W-2];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat_value(input logic [SUM_W-1:0] sum);
        logic [DATA_WIDTH-1:0] res;
        case ({sum[SUM_W-1], sum[SUM_W-2]})
            2'b01:   res = SAT_MAX;
            2'b10:   res = SAT_MIN;
            default: res = sum[DATA_WIDTH-1:0];
        endcase
        return res;
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [DATA_WIDTH-1:0] acc_r     [N_NEURON];
    logic [DATA_WIDTH-1:0] acc_nxt_s [N_NEURON];
    logic [DATA_WIDTH-1:0] base_s    [N_NEURON];
    logic [PROD_W-1:0]     prod_s    [N_NEURON];
    logic [SUM_W-1:0]      sum_s     [N_NEURON];
    logic [N_NEURON-1:0]   hit_s;
    logic                  sticky_r;
    logic                  in_ready_r;
    logic                  valid_r;
    logic                  overflow_r;
    logic [10*DATA_WIDTH-1:0] layer_out_r;
    logic                  accept_s;

    assign accept_s  = in_valid & in_ready_r;
    assign in_ready  = in_ready_r;
    assign valid     = valid_r;
    assign overflow  = overflow_r;
    assign layer_out = layer_out_r;

    // Per-neuron multiply-accumulate with saturation; the first beat starts from bias.
    always_comb begin
        for (int k = 0; k < N_NEURON; k++) begin
            prod_s[k] = PROD_W'($signed(act) * $signed(weights[k*W_WIDTH +: W_WIDTH]));
            if (state_r == IDLE) begin
                base_s[k] = bias[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                base_s[k] = acc_r[k];
            end
            sum_s[k] = {base_s[k][DATA_WIDTH-1], base_s[k]}
                     + {{(SUM_W-PROD_W){prod_s[k][PROD_W-1]}}, prod_s[k]};
            acc_nxt_s[k] = sat_value(sum_s[k]);
            hit_s[k]     = sat_hit(sum_s[k]);
        end
    end

    // Next-state logic: count accepted beats, hold in EMIT for exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ACC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACC: begin
                if (accept_s && (cnt_r == LAST_CNT)) begin
                    state_nxt_s = EMIT;
                end else begin
                    state_nxt_s = ACC;
                end
            end
            EMIT:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: accumulators, beat counter, sticky saturation flag and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= '0;
            sticky_r    <= 1'b0;
            in_ready_r  <= 1'b1;
            valid_r     <= 1'b0;
            overflow_r  <= 1'b0;
            layer_out_r <= '0;
            for (int k = 0; k < N_NEURON; k++) begin
                acc_r[k] <= '0;
            end
        end else begin
            valid_r    <= 1'b0;
            in_ready_r <= (state_nxt_s != EMIT);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        acc_r    <= acc_nxt_s;
                        cnt_r    <= CNT_W'(1);
                        sticky_r <= |hit_s;
                    end
                end
                ACC: begin
                    if (accept_s) begin
                        acc_r    <= acc_nxt_s;
                        cnt_r    <= cnt_r + CNT_W'(1);
                        sticky_r <= sticky_r | (|hit_s);
                    end
                end
                EMIT: begin
                    for (int k = 0; k < N_NEURON; k++) begin
                        layer_out_r[k*DATA_WIDTH +: DATA_WIDTH] <= acc_r[k];
                    end
                    overflow_r <= sticky_r;
                    valid_r    <= 1'b1;
                    cnt_r      <= '0;
                    sticky_r   <= 1'b0;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_layer_accum.sv
// Randomized and directed bench for output_layer_accum (N_IN=4) against an
// integer reference model of the bias-initialised saturating dot products.
module tb_output_layer_accum;

    localparam int DW  = 29;
    localparam int AW  = 8;
    localparam int WW  = 8;
    localparam int NIN = 4;
    localparam int NN  = 10;
    localparam longint MAXV = (longint'(1) <<< (DW-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DW-1));

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [AW-1:0]     act = '0;
    logic [NN*WW-1:0]  weights = '0;
    logic [NN*DW-1:0]  bias = '0;
    logic [NN*DW-1:0]  layer_out;
    logic              valid;
    logic              overflow;

    always #5 clk = ~clk;

    output_layer_accum #(
        .DATA_WIDTH(DW), .ACT_WIDTH(AW), .W_WIDTH(WW), .N_IN(NIN)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .act(act), .weights(weights), .bias(bias),
        .layer_out(layer_out), .valid(valid), .overflow(overflow)
    );

    int     total = 0;
    int     bad = 0;
    int     pulses = 0;
    logic   prev_valid = 1'b0;
    longint bias_m [NN];
    int     act_m  [NIN];
    int     w_m    [NIN][NN];
    longint exp_acc [NN];
    longint exp_ovf;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Count valid pulses and flag back-to-back highs.
    always @(negedge clk) begin
        if (valid) begin
            pulses++;
            chk("valid_gap", longint'(prev_valid), 0);
        end
        prev_valid = valid;
    end

    task automatic model();
        for (int k = 0; k < NN; k++) begin
            longint a;
            a = bias_m[k];
            for (int i = 0; i < NIN; i++) begin
                if (i == 0) a = bias_m[k];
                a = a + longint'(act_m[i]) * longint'(w_m[i][k]);
                if (a > MAXV) begin a = MAXV; exp_ovf = 1; end
                else if (a < MINV) begin a = MINV; exp_ovf = 1; end
            end
            exp_acc[k] = a;
        end
    endtask

    function automatic longint neuron(input int k);
        logic [DW-1:0] v;
        v = layer_out[k*DW +: DW];
        return longint'($signed(v));
    endfunction

    task automatic drive_beat(input int i);
        act = act_m[i][AW-1:0];
        for (int k = 0; k < NN; k++) weights[k*WW +: WW] = w_m[i][k][WW-1:0];
    endtask

    task automatic scramble();
        act = AW'($urandom);
        for (int k = 0; k < NN; k++) weights[k*WW +: WW] = WW'($urandom);
        for (int k = 0; k < NN; k++) bias[k*DW +: DW] = DW'($urandom);
    endtask

    // Drive one full frame (inputs change 1 time unit after the edge), then check the emit.
    task automatic run_frame(input string name, input int gap_min, input int gap_max);
        int p0;
        int gap;
        int am_dut;
        int am_exp;
        exp_ovf = 0;
        model();
        p0 = pulses;
        for (int k = 0; k < NN; k++) bias[k*DW +: DW] = bias_m[k][DW-1:0];
        for (int i = 0; i < NIN; i++) begin
            drive_beat(i);
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (i == 0) for (int k = 0; k < NN; k++) bias[k*DW +: DW] = DW'($urandom);
            if (i != NIN-1) begin
                gap = $urandom_range(gap_min, gap_max);
                if (gap > 0) begin
                    in_valid = 1'b0;
                    scramble();
                    repeat (gap) @(posedge clk);
                    #1;
                end
            end
        end
        chk({name, "_rdy_emit"}, longint'(in_ready), 0);
        chk({name, "_valid_early"}, longint'(valid), 0);
        scramble();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, "_valid"}, longint'(valid), 1);
        chk({name, "_rdy_after"}, longint'(in_ready), 1);
        chk({name, "_ovf"}, longint'(overflow), exp_ovf);
        am_dut = 0;
        am_exp = 0;
        for (int k = 0; k < NN; k++) begin
            chk($sformatf("%s_n%0d", name, k), neuron(k), exp_acc[k]);
            if (neuron(k) > neuron(am_dut)) am_dut = k;
            if (exp_acc[k] > exp_acc[am_exp]) am_exp = k;
        end
        chk({name, "_argmax"}, am_dut, am_exp);
        @(posedge clk); #1;
        chk({name, "_valid_low"}, longint'(valid), 0);
        chk({name, "_pulses"}, pulses - p0, 1);
    endtask

    task automatic set_basic();
        for (int k = 0; k < NN; k++) bias_m[k] = 0;
        for (int i = 0; i < NIN; i++) begin
            act_m[i] = 1;
            for (int k = 0; k < NN; k++) w_m[i][k] = k;
        end
    endtask

    task automatic set_sat();
        for (int k = 0; k < NN; k++) bias_m[k] = 0;
        bias_m[0] = 268435455;
        for (int i = 0; i < NIN; i++) begin
            act_m[i] = 127;
            for (int k = 0; k < NN; k++) w_m[i][k] = 0;
            w_m[i][0] = 127;
        end
    endtask

    task automatic set_random();
        for (int k = 0; k < NN; k++) begin
            case ($urandom_range(0, 2))
                0:       bias_m[k] = MAXV - longint'($urandom_range(0, 40000));
                1:       bias_m[k] = MINV + longint'($urandom_range(0, 40000));
                default: bias_m[k] = longint'($urandom_range(0, 32'h1FFF_FFFF)) + MINV;
            endcase
        end
        for (int i = 0; i < NIN; i++) begin
            act_m[i] = int'($urandom_range(0, 255)) - 128;
            for (int k = 0; k < NN; k++) w_m[i][k] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    initial begin
        #12;
        chk("rst_layer_out", longint'(|layer_out), 0);
        chk("rst_valid", longint'(valid), 0);
        chk("rst_ovf", longint'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_rdy", longint'(in_ready), 1);

        set_basic();
        run_frame("basic", 0, 0);

        for (int k = 0; k < NN; k++) bias_m[k] = k;
        for (int i = 0; i < NIN; i++) begin
            act_m[i] = -3;
            for (int k = 0; k < NN; k++) w_m[i][k] = 2;
        end
        run_frame("signed", 0, 0);

        set_basic();
        run_frame("bubble", 3, 3);

        set_sat();
        run_frame("sat", 0, 0);
        set_basic();
        run_frame("clean", 0, 0);
        set_sat();
        run_frame("sat2", 0, 1);

        // Partial frame then asynchronous reset in the middle of a cycle.
        set_random();
        for (int i = 0; i < 2; i++) begin
            drive_beat(i);
            for (int k = 0; k < NN; k++) bias[k*DW +: DW] = bias_m[k][DW-1:0];
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_layer_out", longint'(|layer_out), 0);
        chk("midrst_valid", longint'(valid), 0);
        chk("midrst_ovf", longint'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_rdy", longint'(in_ready), 1);
        set_basic();
        run_frame("after_rst", 0, 0);

        for (int f = 0; f < 8; f++) begin
            set_random();
            run_frame($sformatf("rand%0d", f), 0, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
